mem_port_arbiter: RTL and testbench

- Shares the single 8-bit RAM port (address, write data, read data, enable, write-enable) between two requesters: the CPU memory interface and a DMA/program-loader engine.
- Each requester uses a req/ack handshake. The block arbitrates between them, latches the winning command, sequences the RAM access over a fixed latency and returns read data.
- Sits between the CPU's MAR/bus interface and the RAM model, so the CPU and loader never drive the RAM port at the same time.

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single 8-bit RAM port: CPU and DMA/loader share
// the port via req/ack, with round-robin or fixed CPU priority and a fixed RAM latency.
module mem_port_arbiter #(
  parameter int RAM_LAT    = 1,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  input  logic       dma_req,
  input  logic       dma_we,
  input  logic [7:0] dma_addr,
  input  logic [7:0] dma_wdata,
  output logic       dma_ack,
  output logic [7:0] dma_rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_en,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic       busy,
  output logic       owner
);

  // Handshake: a requester holds req and its command stable until its ack
  // pulses for one cycle; the command is sampled only on the grant edge, and
  // a req still high the cycle after ack is a fresh request.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(RAM_LAT - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       last_owner;
  logic       mem_we_q;
  logic       grant;
  logic       grant_dma;
  logic       access_done;

  assign access_done = (state == ACCESS) && (cnt == LAST_CNT);

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_dma  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          grant = 1'b1;
          // On a tie the DMA wins only under round-robin when the CPU went last.
          grant_dma  = dma_req && (!cpu_req || ((FIXED_PRIO == 1'b0) && (last_owner == 1'b0)));
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == LAST_CNT) state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
        // The owner is still holding req until it sees ack, so only the other side may chain in.
        if (owner ? cpu_req : dma_req) begin
          grant      = 1'b1;
          grant_dma  = ~owner;
          state_next = ACCESS;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      mem_we_q   <= 1'b0;
      mem_addr   <= 8'h00;
      mem_wdata  <= 8'h00;
      cpu_rdata  <= 8'h00;
      dma_rdata  <= 8'h00;
    end else begin
      state <= state_next;
      if ((state == ACCESS) && (cnt != LAST_CNT)) cnt <= cnt + 4'd1;
      else cnt <= 4'd0;
      if (grant) begin
        owner      <= grant_dma;
        last_owner <= grant_dma;
        mem_we_q   <= grant_dma ? dma_we    : cpu_we;
        mem_addr   <= grant_dma ? dma_addr  : cpu_addr;
        mem_wdata  <= grant_dma ? dma_wdata : cpu_wdata;
      end
      if (access_done && !mem_we_q) begin
        if (owner) dma_rdata <= mem_rdata;
        else cpu_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en  = (state == ACCESS);
  assign mem_we  = (state == ACCESS) && mem_we_q;
  assign busy    = (state != IDLE);
  assign cpu_ack = (state == RESP) && !owner;
  assign dma_ack = (state == RESP) && owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance a (RAM_LAT=1, round-robin) and
// instance b (RAM_LAT=3, fixed CPU priority), each with its own RAM model.
module tb_mem_port_arbiter;

  logic clk;
  int   total;
  int   bad;

  logic       a_reset, a_cpu_req, a_cpu_we, a_dma_req, a_dma_we;
  logic [7:0] a_cpu_addr, a_cpu_wdata, a_dma_addr, a_dma_wdata;
  logic       a_cpu_ack, a_dma_ack, a_mem_en, a_mem_we, a_busy, a_owner;
  logic [7:0] a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic       b_reset, b_cpu_req, b_cpu_we, b_dma_req, b_dma_we;
  logic [7:0] b_cpu_addr, b_cpu_wdata, b_dma_addr, b_dma_wdata;
  logic       b_cpu_ack, b_dma_ack, b_mem_en, b_mem_we, b_busy, b_owner;
  logic [7:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  logic [7:0] ram_a [0:255];
  logic [7:0] ram_b [0:255];
  logic       pre_en;
  logic [7:0] pre_addr, pre_data;

  mem_port_arbiter #(.RAM_LAT(1), .FIXED_PRIO(1'b0)) dut_a (
    .clk(clk), .reset(a_reset),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
    .dma_req(a_dma_req), .dma_we(a_dma_we), .dma_addr(a_dma_addr), .dma_wdata(a_dma_wdata),
    .dma_ack(a_dma_ack), .dma_rdata(a_dma_rdata),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_en(a_mem_en), .mem_we(a_mem_we),
    .mem_rdata(a_mem_rdata), .busy(a_busy), .owner(a_owner)
  );

  mem_port_arbiter #(.RAM_LAT(3), .FIXED_PRIO(1'b1)) dut_b (
    .clk(clk), .reset(b_reset),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
    .dma_ack(b_dma_ack), .dma_rdata(b_dma_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
  );

  // clock / RAM models
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign a_mem_rdata = ram_a[a_mem_addr];
  assign b_mem_rdata = ram_b[b_mem_addr];

  always @(posedge clk) begin
    if (pre_en) begin
      ram_a[pre_addr] <= pre_data;
      ram_b[pre_addr] <= pre_data;
    end else begin
      if (a_mem_en && a_mem_we) ram_a[a_mem_addr] <= a_mem_wdata;
      if (b_mem_en && b_mem_we) ram_b[b_mem_addr] <= b_mem_wdata;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic clear_a();
    a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = 0; a_cpu_wdata = 0;
    a_dma_req = 0; a_dma_we = 0; a_dma_addr = 0; a_dma_wdata = 0;
  endtask

  task automatic clear_b();
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
    b_dma_req = 0; b_dma_we = 0; b_dma_addr = 0; b_dma_wdata = 0;
  endtask

  task automatic reset_a();
    @(negedge clk);
    a_reset = 1'b0;
    clear_a();
    step(2);
    a_reset = 1'b1;
  endtask

  task automatic reset_b();
    @(negedge clk);
    b_reset = 1'b0;
    clear_b();
    step(2);
    b_reset = 1'b1;
  endtask

  // scenarios
  task automatic test_reset();
    step(1);
    total++; if ({a_busy, a_mem_en, a_mem_we, a_cpu_ack, a_dma_ack, a_owner} !== 6'b0) begin
      bad++; $display("FAIL rst_a_flags got=%b exp=000000", {a_busy, a_mem_en, a_mem_we, a_cpu_ack, a_dma_ack, a_owner});
    end
    total++; if ({a_mem_addr, a_mem_wdata, a_cpu_rdata, a_dma_rdata} !== 32'h0) begin
      bad++; $display("FAIL rst_a_data got=%h exp=00000000", {a_mem_addr, a_mem_wdata, a_cpu_rdata, a_dma_rdata});
    end
    total++; if ({b_busy, b_mem_en, b_mem_we, b_cpu_ack, b_dma_ack, b_owner} !== 6'b0) begin
      bad++; $display("FAIL rst_b_flags got=%b exp=000000", {b_busy, b_mem_en, b_mem_we, b_cpu_ack, b_dma_ack, b_owner});
    end
    total++; if ({b_mem_addr, b_mem_wdata, b_cpu_rdata, b_dma_rdata} !== 32'h0) begin
      bad++; $display("FAIL rst_b_data got=%h exp=00000000", {b_mem_addr, b_mem_wdata, b_cpu_rdata, b_dma_rdata});
    end
  endtask

  task automatic test_cpu_read();
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 8'h10;
    total++; if (a_mem_en !== 1'b0) begin bad++; $display("FAIL rd_c0_en got=%b exp=0", a_mem_en); end
    step(1);
    total++; if ({a_mem_en, a_mem_we, a_mem_addr, a_cpu_ack} !== {1'b1, 1'b0, 8'h10, 1'b0}) begin
      bad++; $display("FAIL rd_c1 en/we/addr/ack got=%b/%b/%h/%b exp=1/0/10/0", a_mem_en, a_mem_we, a_mem_addr, a_cpu_ack);
    end
    step(1);
    total++; if ({a_cpu_ack, a_dma_ack, a_mem_en} !== 3'b100) begin
      bad++; $display("FAIL rd_c2 ack/dack/en got=%b exp=100", {a_cpu_ack, a_dma_ack, a_mem_en});
    end
    total++; if (a_cpu_rdata !== 8'h5A) begin bad++; $display("FAIL rd_cpu_rdata got=%h exp=5a", a_cpu_rdata); end
    total++; if (a_dma_rdata !== 8'h00) begin bad++; $display("FAIL rd_dma_rdata got=%h exp=00", a_dma_rdata); end
    a_cpu_req = 0;
    step(1);
    total++; if ({a_busy, a_cpu_ack} !== 2'b00) begin bad++; $display("FAIL rd_c3 busy/ack got=%b exp=00", {a_busy, a_cpu_ack}); end
  endtask

  // Tie in IDLE where the CPU is expected to win, DMA chained back-to-back.
  task automatic tie_round_a(input logic [7:0] ca, input logic [7:0] da,
                             input logic [7:0] cexp, input logic [7:0] dexp);
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = ca;
    a_dma_req = 1; a_dma_we = 0; a_dma_addr = da;
    step(1);
    total++; if ({a_owner, a_mem_en, a_mem_addr} !== {1'b0, 1'b1, ca}) begin
      bad++; $display("FAIL tie_c1 owner/en/addr got=%b/%b/%h exp=0/1/%h", a_owner, a_mem_en, a_mem_addr, ca);
    end
    step(1);
    total++; if ({a_cpu_ack, a_dma_ack, a_mem_en, a_cpu_rdata} !== {3'b100, cexp}) begin
      bad++; $display("FAIL tie_c2 ack/dack/en/rdata got=%b%b%b/%h exp=100/%h", a_cpu_ack, a_dma_ack, a_mem_en, a_cpu_rdata, cexp);
    end
    a_cpu_req = 0;
    step(1);
    total++; if ({a_owner, a_mem_en, a_busy, a_mem_addr} !== {3'b111, da}) begin
      bad++; $display("FAIL tie_c3_b2b owner/en/busy/addr got=%b%b%b/%h exp=111/%h", a_owner, a_mem_en, a_busy, a_mem_addr, da);
    end
    step(1);
    total++; if ({a_dma_ack, a_cpu_ack, a_dma_rdata, a_cpu_rdata} !== {2'b10, dexp, cexp}) begin
      bad++; $display("FAIL tie_c4 dack/ack/drd/crd got=%b%b/%h/%h exp=10/%h/%h", a_dma_ack, a_cpu_ack, a_dma_rdata, a_cpu_rdata, dexp, cexp);
    end
    a_dma_req = 0;
    step(1);
  endtask

  task automatic test_round_robin();
    reset_a();
    tie_round_a(8'h40, 8'h50, 8'h11, 8'h22);
    tie_round_a(8'h41, 8'h51, 8'h33, 8'h44);
    // CPU-only write leaves last_owner=CPU, so the next tie goes to DMA.
    a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 8'h90; a_cpu_wdata = 8'h99;
    step(1);
    total++; if ({a_mem_we, a_mem_wdata} !== {1'b1, 8'h99}) begin
      bad++; $display("FAIL rr_wr we/wdata got=%b/%h exp=1/99", a_mem_we, a_mem_wdata);
    end
    step(1);
    a_cpu_req = 0;
    step(1);
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 8'h40;
    a_dma_req = 1; a_dma_we = 0; a_dma_addr = 8'h50;
    step(1);
    total++; if ({a_owner, a_mem_addr} !== {1'b1, 8'h50}) begin
      bad++; $display("FAIL rr_dma_first owner/addr got=%b/%h exp=1/50", a_owner, a_mem_addr);
    end
    step(1);
    total++; if ({a_dma_ack, a_cpu_ack} !== 2'b10) begin bad++; $display("FAIL rr_dack got=%b exp=10", {a_dma_ack, a_cpu_ack}); end
    a_dma_req = 0;
    step(1);
    total++; if ({a_owner, a_mem_en, a_mem_addr} !== {2'b01, 8'h40}) begin
      bad++; $display("FAIL rr_cpu_b2b owner/en/addr got=%b%b/%h exp=01/40", a_owner, a_mem_en, a_mem_addr);
    end
    step(1);
    total++; if ({a_cpu_ack, a_cpu_rdata} !== {1'b1, 8'h11}) begin
      bad++; $display("FAIL rr_cack ack/rdata got=%b/%h exp=1/11", a_cpu_ack, a_cpu_rdata);
    end
    a_cpu_req = 0;
    step(1);
  endtask

  task automatic test_fixed_prio();
    reset_b();
    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 8'h60;
    b_dma_req = 1; b_dma_we = 0; b_dma_addr = 8'h70;
    step(1);
    total++; if ({b_owner, b_mem_en, b_mem_addr} !== {2'b01, 8'h60}) begin
      bad++; $display("FAIL fp_c1 owner/en/addr got=%b%b/%h exp=01/60", b_owner, b_mem_en, b_mem_addr);
    end
    step(3);
    total++; if ({b_cpu_ack, b_mem_en, b_cpu_rdata} !== {2'b10, 8'h66}) begin
      bad++; $display("FAIL fp_c4 ack/en/rdata got=%b%b/%h exp=10/66", b_cpu_ack, b_mem_en, b_cpu_rdata);
    end
    step(1);
    total++; if ({b_owner, b_mem_en, b_mem_addr} !== {2'b11, 8'h70}) begin
      bad++; $display("FAIL fp_c5_b2b owner/en/addr got=%b%b/%h exp=11/70", b_owner, b_mem_en, b_mem_addr);
    end
    step(3);
    total++; if ({b_dma_ack, b_cpu_ack, b_dma_rdata} !== {2'b10, 8'h77}) begin
      bad++; $display("FAIL fp_c8 dack/ack/drd got=%b%b/%h exp=10/77", b_dma_ack, b_cpu_ack, b_dma_rdata);
    end
    b_dma_req = 0;
    step(1);
    total++; if ({b_owner, b_mem_en, b_mem_addr} !== {2'b01, 8'h60}) begin
      bad++; $display("FAIL fp_c9_b2b owner/en/addr got=%b%b/%h exp=01/60", b_owner, b_mem_en, b_mem_addr);
    end
    step(3);
    total++; if (b_cpu_ack !== 1'b1) begin bad++; $display("FAIL fp_c12_ack got=%b exp=1", b_cpu_ack); end
    b_cpu_req = 0;
    step(1);
    total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL fp_c13_idle busy got=%b exp=0", b_busy); end
    // last_owner is CPU here; fixed priority still hands the tie to the CPU.
    b_cpu_req = 1; b_dma_req = 1; b_dma_addr = 8'h71;
    step(1);
    total++; if ({b_owner, b_mem_addr} !== {1'b0, 8'h60}) begin
      bad++; $display("FAIL fp_tie_cpu owner/addr got=%b/%h exp=0/60", b_owner, b_mem_addr);
    end
    step(3);
    b_cpu_req = 0;
    step(4);
    total++; if ({b_dma_ack, b_dma_rdata} !== {1'b1, 8'h7E}) begin
      bad++; $display("FAIL fp_tail dack/drd got=%b/%h exp=1/7e", b_dma_ack, b_dma_rdata);
    end
    b_dma_req = 0;
    step(1);
  endtask

  task automatic test_dma_write();
    b_dma_req = 1; b_dma_we = 1; b_dma_addr = 8'hFE; b_dma_wdata = 8'hC3;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      total++; if ({b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_dma_ack} !== {2'b11, 8'hFE, 8'hC3, 1'b0}) begin
        bad++; $display("FAIL wr_c%0d en/we/addr/wd/dack got=%b%b/%h/%h/%b exp=11/fe/c3/0", i, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_dma_ack);
      end
    end
    step(1);
    total++; if ({b_dma_ack, b_mem_en, b_mem_we, b_dma_rdata} !== {3'b100, 8'h7E}) begin
      bad++; $display("FAIL wr_c4 dack/en/we/drd got=%b%b%b/%h exp=100/7e", b_dma_ack, b_mem_en, b_mem_we, b_dma_rdata);
    end
    b_dma_req = 0; b_dma_we = 0;
    step(1);
    total++; if (ram_b[8'hFE] !== 8'hC3) begin bad++; $display("FAIL wr_ram got=%h exp=c3", ram_b[8'hFE]); end
  endtask

  task automatic test_reset_mid_access();
    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 8'h60;
    step(2);
    total++; if (b_mem_en !== 1'b1) begin bad++; $display("FAIL ra_pre_en got=%b exp=1", b_mem_en); end
    b_reset = 1'b0;
    #1;
    total++; if ({b_mem_en, b_busy, b_cpu_rdata} !== {2'b00, 8'h00}) begin
      bad++; $display("FAIL ra_async en/busy/crd got=%b%b/%h exp=00/00", b_mem_en, b_busy, b_cpu_rdata);
    end
    b_cpu_req = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      total++; if (b_cpu_ack !== 1'b0) begin bad++; $display("FAIL ra_no_ack cyc=%0d got=%b exp=0", i, b_cpu_ack); end
    end
    b_reset = 1'b1;
    step(1);
    total++; if ({b_cpu_ack, b_cpu_rdata} !== {1'b0, 8'h00}) begin
      bad++; $display("FAIL ra_after ack/crd got=%b/%h exp=0/00", b_cpu_ack, b_cpu_rdata);
    end
    b_cpu_req = 1; b_cpu_addr = 8'h61;
    step(4);
    total++; if ({b_cpu_ack, b_cpu_rdata} !== {1'b1, 8'h5C}) begin
      bad++; $display("FAIL ra_new ack/crd got=%b/%h exp=1/5c", b_cpu_ack, b_cpu_rdata);
    end
    b_cpu_req = 0;
    step(1);
  endtask

  task automatic test_addr_hold();
    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 8'h20;
    step(1);
    total++; if (b_mem_addr !== 8'h20) begin bad++; $display("FAIL ah_c1 got=%h exp=20", b_mem_addr); end
    b_cpu_addr = 8'h30;
    for (int i = 2; i <= 4; i++) begin
      step(1);
      total++; if (b_mem_addr !== 8'h20) begin bad++; $display("FAIL ah_c%0d got=%h exp=20", i, b_mem_addr); end
    end
    total++; if ({b_cpu_ack, b_cpu_rdata} !== {1'b1, 8'h2A}) begin
      bad++; $display("FAIL ah_ack ack/crd got=%b/%h exp=1/2a", b_cpu_ack, b_cpu_rdata);
    end
    b_cpu_req = 0;
    step(1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    pre_en = 0; pre_addr = 0; pre_data = 0;
    a_reset = 0; b_reset = 0;
    clear_a();
    clear_b();
    preload(8'h10, 8'h5A); preload(8'h40, 8'h11); preload(8'h50, 8'h22);
    preload(8'h41, 8'h33); preload(8'h51, 8'h44); preload(8'h60, 8'h66);
    preload(8'h70, 8'h77); preload(8'h71, 8'h7E); preload(8'h61, 8'h5C);
    preload(8'h20, 8'h2A); preload(8'h30, 8'h3B); preload(8'hFE, 8'h00);
    step(1);
    a_reset = 1; b_reset = 1;
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_fixed_prio();
    test_dma_write();
    test_reset_mid_access();
    test_addr_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
